// File: rtl/cordic_pkg.sv
// cordic_pkg: mode encoding, MSB-aligned quadrant constants and the elaboration-time
// arctangent table shared by the CORDIC engine and its stages.
package cordic_pkg;
    typedef enum logic {MODE_ROT = 1'b0, MODE_VEC = 1'b1} mode_e;
    // Angles are binary fractions of a full turn; take the top ANGLE_WIDTH bits for any width.
    localparam logic [63:0] Q90 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] Q180 = 64'h8000_0000_0000_0000;
    localparam real PI = 3.14159265358979323846;
    function automatic logic [63:0] atan_lut(input int i, input int aw);
        real t, p, s, sc;
        t = 1.0;
        for (int k = 0; k < i; k++) t = t / 2.0;
        s = PI / 4.0;
        p = t;
        if (i != 0) begin
            s = 0.0;
            for (int k = 0; k < 40; k++) begin
                s = (k % 2 == 0) ? s + p / real'(2 * k + 1) : s - p / real'(2 * k + 1);
                p = p * t * t;
            end
        end
        sc = 1.0;
        for (int k = 0; k < aw; k++) sc = sc * 2.0;
        return longint'(s / (2.0 * PI) * sc);
    endfunction
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered micro-rotation by 2^-SHIFT; valid and mode travel with the data.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int IW = 24,
    parameter int AW = 32,
    parameter int SHIFT = 0,
    parameter logic [AW-1:0] ATAN = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_adv,
    input  logic                 i_valid,
    input  logic                 i_mode,
    input  logic signed [IW-1:0] i_x,
    input  logic signed [IW-1:0] i_y,
    input  logic [AW-1:0]        i_z,
    output logic                 o_valid,
    output logic                 o_mode,
    output logic signed [IW-1:0] o_x,
    output logic signed [IW-1:0] o_y,
    output logic [AW-1:0]        o_z
);
    logic r_valid, r_mode, w_d;
    logic signed [IW-1:0] r_x, r_y, w_xs, w_ys;
    logic [AW-1:0] r_z;
    assign w_xs = i_x >>> SHIFT;
    assign w_ys = i_y >>> SHIFT;
    assign w_d = (i_mode == MODE_VEC) ? !i_y[IW-1] : i_z[AW-1];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_mode <= 1'b0;
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_mode <= i_mode;
            r_x <= w_d ? i_x + w_ys : i_x - w_ys;
            r_y <= w_d ? i_y - w_xs : i_y + w_xs;
            r_z <= w_d ? i_z + ATAN : i_z - ATAN;
        end
    end
    assign o_valid = r_valid;
    assign o_mode = r_mode;
    assign o_x = r_x;
    assign o_y = r_y;
    assign o_z = r_z;
endmodule

// File: rtl/cordic_engine.sv
// cordic_engine: fully pipelined rotation/vectoring CORDIC with valid/ready stall,
// quadrant pre-rotation, optional gain compensation and saturating outputs.
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int ITERATIONS = 16,
    parameter int GUARD_BITS = 2,
    parameter int GAIN_COMP = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mode,
    input  logic signed [DATA_WIDTH-1:0] in_x,
    input  logic signed [DATA_WIDTH-1:0] in_y,
    input  logic [ANGLE_WIDTH-1:0]       in_angle,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_mode,
    output logic signed [DATA_WIDTH-1:0] out_x,
    output logic signed [DATA_WIDTH-1:0] out_y,
    output logic [ANGLE_WIDTH-1:0]       out_angle
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ANGLE_WIDTH;
    localparam int N = ITERATIONS;
    // Fraction bits below the input LSB keep accumulated truncation well under one output LSB.
    localparam int FB = 6;
    localparam int IW = DW + GUARD_BITS + FB;
    localparam logic [AW-1:0] P90 = Q90[63 -: AW];
    localparam logic [AW-1:0] M90 = P90 + Q180[63 -: AW];
    localparam logic signed [IW-1:0] RND = IW'(2 ** (FB - 1));
    localparam logic signed [IW-1:0] MAXV = IW'(2 ** (DW - 1) - 1);
    localparam logic signed [IW-1:0] MINV = ~MAXV;

    function automatic logic [DW-1:0] sat(input logic signed [IW-1:0] v);
        return (v > MAXV) ? MAXV[DW-1:0] : (v < MINV) ? MINV[DW-1:0] : v[DW-1:0];
    endfunction

    logic w_adv, w_vec, w_rq1, w_rq2, w_vh, w_vl, w_ccw, w_cw, w_zero;
    logic signed [IW-1:0] w_xe, w_ye, w_px, w_py, w_gx, w_gy, w_rx, w_ry;
    logic [AW-1:0] w_pz;
    logic r_pv, r_pm, r_ov, r_om;
    logic signed [IW-1:0] r_px, r_py;
    logic [AW-1:0] r_pz, r_oz;
    logic [DW-1:0] r_ox, r_oy;
    logic w_v [0:N];
    logic w_m [0:N];
    logic signed [IW-1:0] w_x [0:N];
    logic signed [IW-1:0] w_y [0:N];
    logic [AW-1:0] w_z [0:N];

    assign w_adv = !r_ov | out_ready;
    assign in_ready = w_adv;
    assign w_xe = {{GUARD_BITS{in_x[DW-1]}}, in_x, {FB{1'b0}}};
    assign w_ye = {{GUARD_BITS{in_y[DW-1]}}, in_y, {FB{1'b0}}};
    assign w_vec = (in_mode == MODE_VEC);
    assign w_rq1 = !w_vec && in_angle[AW-1:AW-2] == 2'b01;
    assign w_rq2 = !w_vec && in_angle[AW-1:AW-2] == 2'b10;
    assign w_vh = w_vec && in_x[DW-1] && in_y[DW-1];
    assign w_vl = w_vec && in_x[DW-1] && !in_y[DW-1];
    // Both pre-rotation paths reduce to a +90 or -90 degree swap of x and y.
    assign w_ccw = w_rq1 | w_vh;
    assign w_cw = w_rq2 | w_vl;
    assign w_px = w_ccw ? -w_ye : w_cw ? w_ye : w_xe;
    assign w_py = w_ccw ? w_xe : w_cw ? -w_xe : w_ye;
    assign w_pz = w_vec ? (w_vh ? M90 : w_vl ? P90 : '0)
                        : (w_rq1 ? in_angle - P90 : w_rq2 ? in_angle + P90 : in_angle);

    assign w_v[0] = r_pv;
    assign w_m[0] = r_pm;
    assign w_x[0] = r_px;
    assign w_y[0] = r_py;
    assign w_z[0] = r_pz;

    for (genvar g = 0; g < N; g++) begin : g_stage
        cordic_stage #(
            .IW(IW),
            .AW(AW),
            .SHIFT(g),
            .ATAN(AW'(atan_lut(g, AW)))
        ) u_stage (
            .clock(clock),
            .reset_n(reset_n),
            .i_adv(w_adv),
            .i_valid(w_v[g]),
            .i_mode(w_m[g]),
            .i_x(w_x[g]),
            .i_y(w_y[g]),
            .i_z(w_z[g]),
            .o_valid(w_v[g+1]),
            .o_mode(w_m[g+1]),
            .o_x(w_x[g+1]),
            .o_y(w_y[g+1]),
            .o_z(w_z[g+1])
        );
    end

    assign w_gx = (GAIN_COMP != 0) ? (w_x[N] >>> 1) + (w_x[N] >>> 3) - (w_x[N] >>> 6) - (w_x[N] >>> 9) : w_x[N];
    assign w_gy = (GAIN_COMP != 0) ? (w_y[N] >>> 1) + (w_y[N] >>> 3) - (w_y[N] >>> 6) - (w_y[N] >>> 9) : w_y[N];
    assign w_rx = (w_gx + RND) >>> FB;
    assign w_ry = (w_gy + RND) >>> FB;
    // A zero vector never moves, so its accumulated angle is meaningless and is forced to 0.
    assign w_zero = w_m[N] == MODE_VEC && w_x[N] == '0 && w_y[N] == '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pv <= 1'b0;
            r_pm <= 1'b0;
            r_px <= '0;
            r_py <= '0;
            r_pz <= '0;
            r_ov <= 1'b0;
            r_om <= 1'b0;
            r_ox <= '0;
            r_oy <= '0;
            r_oz <= '0;
        end else if (w_adv) begin
            r_pv <= in_valid;
            r_pm <= in_mode;
            r_px <= w_px;
            r_py <= w_py;
            r_pz <= w_pz;
            r_ov <= w_v[N];
            r_om <= w_m[N];
            r_ox <= sat(w_rx);
            r_oy <= sat(w_ry);
            r_oz <= w_zero ? '0 : w_z[N];
        end
    end

    assign out_valid = r_ov;
    assign out_mode = r_om;
    assign out_x = r_ox;
    assign out_y = r_oy;
    assign out_angle = r_oz;
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: scoreboard bench; a real-arithmetic trigonometric model predicts each
// result, monitors pop and compare whenever a DUT hands a result downstream.
module tb_cordic_engine;
    typedef struct {
        logic mode;
        int x;
        int y;
        logic [31:0] ang;
        longint acc;
        bit chk;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_mode = 1'b0;
    logic signed [15:0] in_x = '0, in_y = '0;
    logic [31:0] in_angle = '0;
    logic out_valid, out_ready = 1'b1, out_mode;
    logic signed [15:0] out_x, out_y;
    logic [31:0] out_angle;
    logic rin_valid = 1'b0, rin_ready, rin_mode = 1'b0;
    logic signed [15:0] rin_x = '0, rin_y = '0;
    logic [31:0] rin_angle = '0;
    logic rout_valid, rout_mode;
    logic signed [15:0] rout_x, rout_y;
    logic [31:0] rout_angle;

    exp_t sb[$];
    exp_t sb_raw[$];
    int n_tests = 0;
    int n_fail = 0;
    longint cyc = 0;
    bit bp = 1'b0;
    real kg;

    cordic_engine dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_angle(in_angle),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_x(out_x), .out_y(out_y), .out_angle(out_angle)
    );

    cordic_engine #(.GAIN_COMP(0)) dut_raw (
        .clock(clock), .reset_n(reset_n),
        .in_valid(rin_valid), .in_ready(rin_ready), .in_mode(rin_mode),
        .in_x(rin_x), .in_y(rin_y), .in_angle(rin_angle),
        .out_valid(rout_valid), .out_ready(1'b1), .out_mode(rout_mode),
        .out_x(rout_x), .out_y(rout_y), .out_angle(rout_angle)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial forever begin
        @(posedge clock);
        #1 out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic int satr(real v);
        return v > 32767.0 ? 32767 : v < -32768.0 ? -32768 : int'(v);
    endfunction

    function automatic exp_t model(logic m, int x, int y, logic [31:0] a, bit gc);
        exp_t e;
        real g, th, pi2;
        pi2 = 2.0 * 3.14159265358979323846;
        g = gc ? kg * 0.607421875 : kg;
        e.mode = m;
        e.acc = 0;
        e.chk = 1'b0;
        if (m == 1'b0) begin
            th = real'(a) / 4294967296.0 * pi2;
            e.x = satr(g * (real'(x) * $cos(th) - real'(y) * $sin(th)));
            e.y = satr(g * (real'(x) * $sin(th) + real'(y) * $cos(th)));
            e.ang = '0;
        end else begin
            e.x = satr(g * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
            e.y = 0;
            e.ang = (x == 0 && y == 0) ? '0 : 32'(longint'($atan2(real'(y), real'(x)) / pi2 * 4294967296.0));
        end
        return e;
    endfunction

    task automatic chk(string nm, longint act, longint expv, longint tol);
        n_tests++;
        if ((act > expv ? act - expv : expv - act) > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, expv, tol);
        end
    endtask

    task automatic compare(string tag, exp_t e, logic m, logic [15:0] x, logic [15:0] y, logic [31:0] a);
        chk({tag, " mode"}, m, e.mode, 0);
        chk({tag, " x"}, $signed(x), e.x, 4);
        chk({tag, " y"}, $signed(y), e.y, 4);
        chk({tag, " angle"}, $signed(a - e.ang), 0, 262144);
        if (e.chk) chk({tag, " latency"}, cyc - e.acc, 18, 0);
    endtask

    always @(negedge clock) begin : mon_main
        exp_t e;
        if (reset_n) begin
            chk("in_ready", in_ready, !out_valid | out_ready, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected output: got x=%0d y=%0d, want none", out_x, out_y);
                end else begin
                    e = sb.pop_front();
                    compare("main", e, out_mode, out_x, out_y, out_angle);
                end
            end
        end
    end

    always @(negedge clock) begin : mon_raw
        exp_t e;
        if (reset_n && rout_valid) begin
            if (sb_raw.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected raw output: got x=%0d, want none", rout_x);
            end else begin
                e = sb_raw.pop_front();
                compare("raw", e, rout_mode, rout_x, rout_y, rout_angle);
            end
        end
    end

    task automatic send(logic m, int x, int y, logic [31:0] a);
        exp_t e;
        e = model(m, x, y, a, 1'b1);
        in_mode = m;
        in_x = 16'(x);
        in_y = 16'(y);
        in_angle = a;
        in_valid = 1'b1;
        for (int w = 0; w < 200 && !in_ready; w++) @(negedge clock);
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send: in_ready got 0 for 200 cycles, want 1");
        end else begin
            e.acc = cyc;
            e.chk = !bp;
            sb.push_back(e);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_raw(logic m, int x, int y, logic [31:0] a);
        exp_t e;
        e = model(m, x, y, a, 1'b0);
        e.acc = cyc;
        e.chk = 1'b1;
        sb_raw.push_back(e);
        rin_mode = m;
        rin_x = 16'(x);
        rin_y = 16'(y);
        rin_angle = a;
        rin_valid = 1'b1;
        @(negedge clock);
        rin_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic m;
        int x, y;
        m = 1'($urandom_range(0, 1));
        if (m == 1'b0) begin
            x = int'($urandom_range(0, 40000)) - 20000;
            y = int'($urandom_range(0, 40000)) - 20000;
        end else begin
            x = int'($urandom_range(1000, 20000)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
            y = int'($urandom_range(0, 40000)) - 20000;
        end
        send(m, x, y, $urandom);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        for (int w = 0; w < 1000 && (sb.size() != 0 || sb_raw.size() != 0); w++) @(negedge clock);
        chk("drain pending", sb.size() + sb_raw.size(), 0, 0);
    endtask

    initial begin
        kg = 1.0;
        for (int i = 0; i < 16; i++) kg = kg * $sqrt(1.0 + 1.0 / real'(1 << (2 * i)));
        #2;
        chk("reset out_valid", out_valid, 0, 0);
        chk("reset out_x", out_x, 0, 0);
        chk("reset out_y", out_y, 0, 0);
        chk("reset out_angle", out_angle, 0, 0);
        chk("reset out_mode", out_mode, 0, 0);
        chk("reset in_ready", in_ready, 1, 0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send(1'b0, 16384, 0, 32'h2000_0000);
        send(1'b0, 16384, 0, 32'hA000_0000);
        send(1'b1, 3000, 4000, 32'h1234_5678);
        send(1'b1, -3000, -4000, 32'h0);
        send(1'b1, 0, 0, 32'h0);
        send(1'b1, -5000, 0, 32'h0);
        send(1'b0, -32768, 0, 32'h4000_0000);
        send(1'b0, 16384, 0, 32'h3FFF_FFFF);
        send(1'b0, 16384, 0, 32'h4000_0000);
        send(1'b0, 16384, 0, 32'h7FFF_FFFF);
        send(1'b0, 16384, 0, 32'h8000_0000);
        idle(1);
        send(1'b0, 12000, -7000, 32'hC000_0000);
        idle(2);
        for (int i = 0; i < 6; i++) send_rand();
        send_raw(1'b0, 32767, 32767, 32'h2000_0000);
        send_raw(1'b0, -32768, 0, 32'h0);
        drain();
        bp = 1'b1;
        for (int i = 0; i < 40; i++) send_rand();
        drain();
        bp = 1'b0;
        idle(2);
        for (int i = 0; i < 10; i++) send(1'b0, 10000 + i * 100, -2000, $urandom);
        idle(9);
        chk("pre-reset out_valid", out_valid, 1, 0);
        #2 reset_n = 1'b0;
        #1 chk("async reset out_valid", out_valid, 0, 0);
        sb.delete();
        idle(3);
        #2 reset_n = 1'b1;
        idle(30);
        send(1'b1, 3000, 4000, 32'h0);
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
